// File: rtl/chunk_msg_feeder_pkg.sv
// -----------------------------------------------------------------------------
// chunk_msg_feeder_pkg
// Shared constants and types for the ChunkHasher message feeder.
//   WORDS_PER_BLOCK : 32-bit words in one compression block (fixed at 16)
//   CHUNK_BYTES     : largest message accepted (one 1024-byte chunk)
//   msg_block_t     : one block, word 0 in element [0]
//   feeder_state_e  : feeder FSM states
// -----------------------------------------------------------------------------
package chunk_msg_feeder_pkg;

  localparam int WORDS_PER_BLOCK = 16;
  localparam int CHUNK_BYTES     = 1024;

  typedef logic [WORDS_PER_BLOCK-1:0][31:0] msg_block_t;

  typedef enum logic [2:0] {
    IDLE,
    FILL,
    ISSUE,
    WAIT_ACK,
    WAIT_DONE
  } feeder_state_e;

  // Number of 32-bit words covering len bytes: ceil(len/4).
  // len is at most 1024 here, so 11 bits in and 9 bits (0..256) out suffice.
  function automatic logic [8:0] word_count(input logic [10:0] len);
    logic [10:0] rounded;
    rounded = len + 11'd3;
    return rounded[10:2];
  endfunction

  // Index of the final block: max(1, ceil(nw/16)) - 1.
  function automatic logic [3:0] last_block(input logic [8:0] nw);
    logic [8:0] nw_m1;
    nw_m1 = nw - 9'd1;
    return (nw == 9'd0) ? 4'd0 : nw_m1[7:4];
  endfunction

endpackage

// File: rtl/chunk_msg_feeder_if.sv
// -----------------------------------------------------------------------------
// chunk_msg_feeder_if
// Bundles the host word stream, the ChunkHasher block interface and the
// message status signals of the feeder.
//   Start_I/Len_I         : message start pulse and byte length
//   Data_I/Data_vld_I/Data_rdy_O : word stream into the feeder
//   Msg_O/Byte_num_O/Update_O/Addr_I/Vld_I : block interface to the hasher
//   Busy_O/Done_O/Err_O   : message status
// Handshake: a word moves on every rising clock edge where Data_vld_I and
// Data_rdy_O are both 1. The source may raise Data_vld_I at any time and must
// hold Data_I stable until the transfer; the feeder may drop Data_rdy_O at any
// time, and a word offered while Data_rdy_O is 0 is simply not taken.
// Modport master = the feeder, slave = the environment driving it.
// -----------------------------------------------------------------------------
interface chunk_msg_feeder_if;
  import chunk_msg_feeder_pkg::*;

  logic        Start_I;
  logic [31:0] Len_I;
  logic [31:0] Data_I;
  logic        Data_vld_I;
  logic        Data_rdy_O;
  msg_block_t  Msg_O;
  logic [31:0] Byte_num_O;
  logic        Update_O;
  logic [9:0]  Addr_I;
  logic        Vld_I;
  logic        Busy_O;
  logic        Done_O;
  logic        Err_O;

  modport master (
    input  Start_I, Len_I, Data_I, Data_vld_I, Addr_I, Vld_I,
    output Data_rdy_O, Msg_O, Byte_num_O, Update_O, Busy_O, Done_O, Err_O
  );

  modport slave (
    output Start_I, Len_I, Data_I, Data_vld_I, Addr_I, Vld_I,
    input  Data_rdy_O, Msg_O, Byte_num_O, Update_O, Busy_O, Done_O, Err_O
  );

endinterface

// File: rtl/chunk_msg_feeder.sv
// -----------------------------------------------------------------------------
// chunk_msg_feeder
// Producer side of the ChunkHasher block interface. Takes one message (up to
// one 1024-byte chunk) as a 32-bit word stream, packs it into 16-word blocks
// with the tail of the final block zero-padded, presents each block with a
// one-cycle Update_O pulse and holds it until the hasher moves its block
// address. Done_O pulses once the hasher reports a valid final hash.
// Ports:
//   Clk         : clock
//   Rst_n       : asynchronous active-low reset
//   bus         : chunk_msg_feeder_if.master (stream, hasher and status signals)
//   o_dbg_state : current FSM state, for observation only
// MAX_BYTES must stay <= 1024: the word/block counters are sized for one chunk.
// -----------------------------------------------------------------------------
module chunk_msg_feeder
  import chunk_msg_feeder_pkg::*;
#(
  parameter int MAX_BYTES = CHUNK_BYTES
) (
  input  logic                   Clk,
  input  logic                   Rst_n,
  chunk_msg_feeder_if.master     bus,
  output feeder_state_e          o_dbg_state
);

  // ---------------------------------------------------------------------------
  // State and datapath registers
  // ---------------------------------------------------------------------------
  feeder_state_e r_state;
  msg_block_t    r_msg;
  logic [31:0]   r_byte_num;
  logic [8:0]    r_nw;        // message words, ceil(Len/4)
  logic [1:0]    r_tail;      // Len % 4, valid bytes in the last word (0 = all)
  logic [3:0]    r_last_blk;  // index of the final block
  logic [4:0]    r_wcnt;      // words written into the current block, 0..16
  logic [8:0]    r_tcnt;      // words taken over the whole message, 0..256
  logic [3:0]    r_bcnt;      // index of the block being filled/presented
  logic [9:0]    r_addr;      // hasher address captured when a block is issued
  logic          r_vld_d;
  logic          r_done;
  logic          r_err;

  feeder_state_e w_next;
  logic          w_rdy;
  logic          w_xfer;
  logic          w_start;
  logic          w_len_ok;
  logic          w_last_word;
  logic          w_blk_full;
  logic          w_final_blk;
  logic          w_addr_moved;
  logic          w_vld_rise;
  logic [8:0]    w_nw_in;
  logic [31:0]   w_word;

  // Keeps bytes 0..n-1 of a word; n = 0 means the word is complete.
  function automatic logic [31:0] tail_mask(input logic [1:0] n);
    logic [31:0] m;
    case (n)
      2'd1:    m = 32'h0000_00FF;
      2'd2:    m = 32'h0000_FFFF;
      2'd3:    m = 32'h00FF_FFFF;
      default: m = 32'hFFFF_FFFF;
    endcase
    return m;
  endfunction

  assign w_len_ok     = (bus.Len_I <= 32'(MAX_BYTES));
  assign w_start      = (r_state == IDLE) && bus.Start_I;
  assign w_nw_in      = word_count(bus.Len_I[10:0]);
  assign w_xfer       = w_rdy && bus.Data_vld_I;
  assign w_last_word  = ((r_tcnt + 9'd1) == r_nw);
  assign w_blk_full   = (r_wcnt == 5'(WORDS_PER_BLOCK - 1));
  assign w_final_blk  = (r_bcnt == r_last_blk);
  assign w_addr_moved = (bus.Addr_I != r_addr);
  assign w_vld_rise   = bus.Vld_I && !r_vld_d;
  assign w_word       = w_last_word ? (bus.Data_I & tail_mask(r_tail)) : bus.Data_I;

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state and stream ready
  // ---------------------------------------------------------------------------
  always_comb begin
    w_next = r_state;
    w_rdy  = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.Start_I && w_len_ok) w_next = FILL;
      end
      FILL: begin
        // Ready only while message words remain; an empty message never asks.
        w_rdy = (r_tcnt != r_nw);
        if (r_nw == 9'd0) begin
          w_next = ISSUE;
        end else if (w_rdy && bus.Data_vld_I && (w_blk_full || w_last_word)) begin
          w_next = ISSUE;
        end
      end
      ISSUE: begin
        w_next = WAIT_ACK;
      end
      WAIT_ACK: begin
        // The final block needs no address step; the hasher will signal Vld.
        if (w_final_blk) begin
          w_next = WAIT_DONE;
        end else if (w_addr_moved) begin
          w_next = FILL;
        end
      end
      WAIT_DONE: begin
        if (w_vld_rise) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath
  // ---------------------------------------------------------------------------
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_msg      <= '0;
      r_byte_num <= '0;
      r_nw       <= '0;
      r_tail     <= '0;
      r_last_blk <= '0;
      r_wcnt     <= '0;
      r_tcnt     <= '0;
      r_bcnt     <= '0;
      r_addr     <= '0;
      r_vld_d    <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      // Vld_I history is tracked always so a level already high when the last
      // block is issued is not mistaken for a fresh rising edge.
      r_vld_d <= bus.Vld_I;
      // Registered so Done_O lands in the same cycle Busy_O drops.
      r_done  <= (r_state == WAIT_DONE) && w_vld_rise;

      if (w_start) begin
        if (w_len_ok) begin
          r_err      <= 1'b0;
          r_byte_num <= bus.Len_I;
          r_nw       <= w_nw_in;
          r_tail     <= bus.Len_I[1:0];
          r_last_blk <= last_block(w_nw_in);
          r_msg      <= '0;
          r_wcnt     <= '0;
          r_tcnt     <= '0;
          r_bcnt     <= '0;
        end else begin
          r_err <= 1'b1;
        end
      end

      if (w_xfer) begin
        r_msg[r_wcnt[3:0]] <= w_word;
        r_wcnt             <= r_wcnt + 5'd1;
        r_tcnt             <= r_tcnt + 9'd1;
      end

      if (r_state == ISSUE) begin
        r_addr <= bus.Addr_I;
      end

      // Block consumed: start the next one from a clean, zeroed register.
      if ((r_state == WAIT_ACK) && !w_final_blk && w_addr_moved) begin
        r_msg  <= '0;
        r_wcnt <= '0;
        r_bcnt <= r_bcnt + 4'd1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign bus.Data_rdy_O = w_rdy;
  assign bus.Msg_O      = r_msg;
  assign bus.Byte_num_O = r_byte_num;
  assign bus.Update_O   = (r_state == ISSUE);
  assign bus.Busy_O     = (r_state != IDLE);
  assign bus.Done_O     = r_done;
  assign bus.Err_O      = r_err;
  assign o_dbg_state    = r_state;

endmodule

// File: tb/tb_chunk_msg_feeder.sv
module tb_chunk_msg_feeder;
  import chunk_msg_feeder_pkg::*;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic clk;
  logic rst_n;
  feeder_state_e dbg_state;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  chunk_msg_feeder_if bus ();

  chunk_msg_feeder dut (
    .Clk         (clk),
    .Rst_n       (rst_n),
    .bus         (bus),
    .o_dbg_state (dbg_state)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard state
  // ---------------------------------------------------------------------------
  logic [511:0] exp_q[$];
  logic [31:0]  words[256];
  logic [511:0] blocks[16];
  int checks = 0;
  int errors = 0;
  int upd_cnt = 0;
  int xfer_cnt = 0;
  int rdy_cnt = 0;
  int cur_len = 0;
  int cur_nw = 0;
  int cur_nb = 0;
  bit abort_run = 0;

  task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Monitor: pops an expected block on every Update_O and counts transfers.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.Data_vld_I && bus.Data_rdy_O) xfer_cnt++;
      if (bus.Data_rdy_O) rdy_cnt++;
      if (bus.Update_O) begin
        upd_cnt++;
        check("upd_expected", {511'b0, exp_q.size() != 0}, 512'd1);
        if (exp_q.size() != 0) check("block", bus.Msg_O, exp_q.pop_front());
        check("byte_num", bus.Byte_num_O, cur_len);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Reference model: words -> zero-padded blocks, pushed to the scoreboard
  // ---------------------------------------------------------------------------
  task automatic build_msg(input int len, input bit rnd);
    logic [31:0]  w;
    logic [511:0] blk;
    int idx;
    cur_len = len;
    cur_nw  = (len + 3) / 4;
    cur_nb  = (cur_nw == 0) ? 1 : (cur_nw + 15) / 16;
    for (int i = 0; i < 256; i++) begin
      if (rnd) words[i] = $urandom;
      else     words[i] = {8'((4*i+3) & 255), 8'((4*i+2) & 255), 8'((4*i+1) & 255), 8'((4*i) & 255)};
    end
    for (int b = 0; b < cur_nb; b++) begin
      blk = '0;
      for (int k = 0; k < 16; k++) begin
        idx = b * 16 + k;
        if (idx < cur_nw) begin
          w = words[idx];
          for (int j = 0; j < 4; j++) begin
            if (idx * 4 + j >= len) w[8*j +: 8] = 8'h00;
          end
          blk[k*32 +: 32] = w;
        end
      end
      blocks[b] = blk;
      exp_q.push_back(blk);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Driver: word source + hasher responder for one message
  // rst_blk >= 0 asserts reset while that block waits for acknowledge.
  // ---------------------------------------------------------------------------
  task automatic run_msg(input int len, input bit rnd, input int ack_dly,
                         input bit mid_start, input int rst_blk);
    int upd0, xfer0, rdy0;
    build_msg(len, rnd);
    upd0 = upd_cnt; xfer0 = xfer_cnt; rdy0 = rdy_cnt;
    abort_run = 0;

    @(posedge clk); #1;
    bus.Start_I = 1'b1; bus.Len_I = len;
    @(posedge clk); #1;
    bus.Start_I = 1'b0;
    check("busy_after_start", bus.Busy_O, 1);
    check("err_after_start", bus.Err_O, 0);

    fork
      begin : feeder
        bit ok;
        int n;
        for (int i = 0; i < cur_nw; i++) begin
          if (rnd && $urandom_range(0, 3) == 0) begin
            bus.Data_vld_I = 1'b0; bus.Data_I = $urandom;
            @(posedge clk); #1;
          end
          bus.Data_I = words[i]; bus.Data_vld_I = 1'b1;
          ok = 0; n = 0;
          while (!ok && n < 3000 && !abort_run) begin
            @(negedge clk); ok = bus.Data_rdy_O;
            @(posedge clk); #1; n++;
          end
          if (abort_run) break;
          if (!ok) begin check("word_accept_timeout", ok, 1); break; end
        end
        bus.Data_vld_I = 1'b0;
      end
      begin : responder
        bit got;
        int n;
        for (int b = 0; b < cur_nb; b++) begin
          got = 0; n = 0;
          while (!got && n < 3000) begin @(negedge clk); got = bus.Update_O; n++; end
          if (!got) begin check("update_timeout", got, 1); abort_run = 1; break; end
          if (b == rst_blk) begin
            @(posedge clk); #2;
            check("pre_rst_state", dbg_state, WAIT_ACK);
            rst_n = 1'b0; #1;
            check("rst_busy", bus.Busy_O, 0);
            check("rst_update", bus.Update_O, 0);
            check("rst_rdy", bus.Data_rdy_O, 0);
            check("rst_msg", bus.Msg_O, 0);
            check("rst_byte_num", bus.Byte_num_O, 0);
            check("rst_done", bus.Done_O, 0);
            check("rst_err", bus.Err_O, 0);
            check("rst_state", dbg_state, IDLE);
            exp_q.delete();
            abort_run = 1;
            break;
          end
          repeat (ack_dly) @(negedge clk);
          check("block_held", bus.Msg_O, blocks[b]);
          if (mid_start && b == 0) begin
            @(posedge clk); #1; bus.Start_I = 1'b1; bus.Len_I = 2000;
            @(posedge clk); #1; bus.Start_I = 1'b0; bus.Len_I = len;
            check("mid_start_err", bus.Err_O, 0);
            check("mid_start_held", bus.Msg_O, blocks[b]);
          end
          @(posedge clk); #1;
          bus.Addr_I = bus.Addr_I + 10'd1;
        end
        if (!abort_run) begin
          @(posedge clk); #1;
          bus.Vld_I = 1'b1;
          got = 0; n = 0;
          while (!got && n < 50) begin @(negedge clk); got = bus.Done_O; n++; end
          check("done_seen", got, 1);
          check("busy_falls_with_done", bus.Busy_O, 0);
          check("msg_held_after_done", bus.Msg_O, blocks[cur_nb-1]);
          check("byte_num_after_done", bus.Byte_num_O, len);
          @(posedge clk); #1;
          bus.Vld_I = 1'b0;
          @(negedge clk);
          check("done_one_cycle", bus.Done_O, 0);
        end
      end
    join

    if (!abort_run) begin
      check("update_count", upd_cnt - upd0, cur_nb);
      check("transfer_count", xfer_cnt - xfer0, cur_nw);
      check("queue_drained", exp_q.size(), 0);
      if (cur_nw == 0) check("no_rdy_empty_msg", rdy_cnt - rdy0, 0);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Test sequence
  // ---------------------------------------------------------------------------
  initial begin
    int u0;
    rst_n = 1'b0;
    bus.Start_I = 1'b0; bus.Len_I = '0; bus.Data_I = '0; bus.Data_vld_I = 1'b0;
    bus.Addr_I = '0; bus.Vld_I = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_busy", bus.Busy_O, 0);
    check("reset_update", bus.Update_O, 0);
    check("reset_rdy", bus.Data_rdy_O, 0);
    check("reset_msg", bus.Msg_O, 0);
    check("reset_byte_num", bus.Byte_num_O, 0);
    check("reset_done", bus.Done_O, 0);
    check("reset_err", bus.Err_O, 0);
    check("reset_state", dbg_state, IDLE);
    @(posedge clk); #1;
    rst_n = 1'b1;

    run_msg(64, 0, 3, 0, -1);
    run_msg(70, 0, 2, 1, -1);
    run_msg(0, 0, 1, 0, -1);
    run_msg(1024, 0, 0, 0, -1);

    // Oversized length: error flag, no message
    u0 = upd_cnt;
    @(posedge clk); #1; bus.Start_I = 1'b1; bus.Len_I = 1025;
    @(posedge clk); #1; bus.Start_I = 1'b0;
    repeat (5) @(negedge clk);
    check("oversize_err", bus.Err_O, 1);
    check("oversize_busy", bus.Busy_O, 0);
    check("oversize_state", dbg_state, IDLE);
    check("oversize_no_update", upd_cnt - u0, 0);
    run_msg(4, 0, 1, 0, -1);

    // Asynchronous reset while block 2 waits for acknowledge
    run_msg(70, 1, 1, 0, 1);
    repeat (2) @(posedge clk); #1;
    rst_n = 1'b1;
    run_msg(37, 1, 1, 1, -1);
    run_msg(200, 1, 2, 0, -1);

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish, %0d checks, %0d errors", checks, errors);
    $fatal(1);
  end

endmodule
